// File: rtl/serdes_pkg.sv
// Shared width and counter sizing for both ends of the bit-serial link.
// Words travel LSB-first; both ends size their bit counters the same way.
package serdes_pkg;

    localparam int SERDES_W_DEFAULT = 4;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/s2p_hold_reg.sv
// One-entry valid/ready output register for assembled words.
// A load is taken only when the slot is free or draining this cycle.
module s2p_hold_reg
    import serdes_pkg::*;
#(
    parameter int W = SERDES_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready_i,
    output logic [W-1:0] dout,
    output logic         valid_o,
    output logic         load_ok
);

    logic [W-1:0] r_dout;
    logic         r_valid;
    logic         w_load_ok;

    assign w_load_ok = !r_valid || ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (load && w_load_ok) begin
            r_dout  <= din;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign dout    = r_dout;
    assign valid_o = r_valid;
    assign load_ok = w_load_ok;

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: shifts qualified LSB-first bits into a
// word and hands it to a one-entry output register, flagging drops.
module s2p_rx
    import serdes_pkg::*;
#(
    parameter int W = SERDES_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_i,
    input  logic         valid_i,
    input  logic         flush_i,
    input  logic         ready_i,
    input  logic         clr_overrun_i,
    output logic [W-1:0] parallel_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         overrun_o
);

    localparam int CW = cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_cnt;
    logic          r_overrun;

    logic [W-1:0]  w_word;
    logic          w_qual;
    logic          w_done;
    logic          w_load_ok;

    // Flush wins over a bit arriving in the same cycle.
    assign w_qual = valid_i && !flush_i;
    assign w_done = w_qual && (r_cnt == LAST);
    assign w_word = {serial_i, r_shreg[W-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
        end else if (w_qual) begin
            r_shreg <= w_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_qual) begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    // A fresh drop in the same cycle outranks the clear request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_done && !w_load_ok) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun_i) begin
            r_overrun <= 1'b0;
        end
    end

    s2p_hold_reg #(
        .W (W)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load    (w_done),
        .din     (w_word),
        .ready_i (ready_i),
        .dout    (parallel_o),
        .valid_o (valid_o),
        .load_ok (w_load_ok)
    );

    assign busy_o    = (r_cnt != '0);
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx at W=4 with hand-computed expected words.
module tb_s2p_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       clr_overrun_i = 1'b0;
    logic [3:0] parallel_o;
    logic       valid_o;
    logic       busy_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;

    s2p_rx #(.W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_i      (serial_i),
        .valid_i       (valid_i),
        .flush_i       (flush_i),
        .ready_i       (ready_i),
        .clr_overrun_i (clr_overrun_i),
        .parallel_o    (parallel_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_i = b;
        valid_i  = 1'b1;
        step();
        valid_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_i      = 1'($urandom);
            valid_i       = 1'($urandom);
            flush_i       = 1'($urandom);
            ready_i       = 1'($urandom);
            clr_overrun_i = 1'($urandom);
            step();
            checks++;
            if ({parallel_o, valid_o, busy_o, overrun_o} !== 7'b0) begin
                $display("FAIL reset_outputs: got par=%h v=%b b=%b o=%b required all 0",
                         parallel_o, valid_o, busy_o, overrun_o);
                errors++;
            end
        end
        {serial_i, valid_i, flush_i, ready_i, clr_overrun_i} = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'hD;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(bits[i]);
            checks++;
            if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
                $display("FAIL basic_busy bit%0d: got busy=%b valid=%b required busy=1 valid=0",
                         i, busy_o, valid_o);
                errors++;
            end
        end
        send_bit(bits[3]);
        checks++;
        if (parallel_o !== 4'hD || valid_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL basic_word: got par=%h v=%b b=%b required par=d v=1 b=0",
                     parallel_o, valid_o, busy_o);
            errors++;
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL basic_one_cycle: got valid=%b required 0", valid_o);
            errors++;
        end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        bits = 4'hA;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i]);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step();
                    checks++;
                    if (busy_o !== 1'b1) begin
                        $display("FAIL gap_busy bit%0d gap%0d: got %b required 1", i, g, busy_o);
                        errors++;
                    end
                end
            end
        end
        checks++;
        if (parallel_o !== 4'hA || valid_o !== 1'b1) begin
            $display("FAIL gap_word: got par=%h v=%b required par=a v=1", parallel_o, valid_o);
            errors++;
        end
        step();
    endtask

    task automatic test_overrun();
        logic [3:0] a;
        logic [3:0] b;
        a = 4'hA;
        b = 4'h3;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(a[i]);
        checks++;
        if (parallel_o !== 4'hA || valid_o !== 1'b1 || overrun_o !== 1'b0) begin
            $display("FAIL ovr_first: got par=%h v=%b o=%b required par=a v=1 o=0",
                     parallel_o, valid_o, overrun_o);
            errors++;
        end
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        checks++;
        if (parallel_o !== 4'hA || valid_o !== 1'b1 || overrun_o !== 1'b1) begin
            $display("FAIL ovr_drop: got par=%h v=%b o=%b required par=a v=1 o=1",
                     parallel_o, valid_o, overrun_o);
            errors++;
        end
        ready_i = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0 || overrun_o !== 1'b1) begin
            $display("FAIL ovr_drain: got v=%b o=%b required v=0 o=1", valid_o, overrun_o);
            errors++;
        end
        clr_overrun_i = 1'b1;
        step();
        clr_overrun_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            $display("FAIL ovr_clear: got %b required 0", overrun_o);
            errors++;
        end
    endtask

    task automatic test_same_cycle_drain();
        logic [3:0] a;
        logic [3:0] c;
        a = 4'h5;
        c = 4'hC;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(a[i]);
        checks++;
        if (parallel_o !== 4'h5 || valid_o !== 1'b1) begin
            $display("FAIL drain_hold: got par=%h v=%b required par=5 v=1", parallel_o, valid_o);
            errors++;
        end
        for (int i = 0; i < 3; i++) send_bit(c[i]);
        ready_i = 1'b1;
        send_bit(c[3]);
        checks++;
        if (parallel_o !== 4'hC || valid_o !== 1'b1 || overrun_o !== 1'b0) begin
            $display("FAIL drain_load: got par=%h v=%b o=%b required par=c v=1 o=0",
                     parallel_o, valid_o, overrun_o);
            errors++;
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            $display("FAIL drain_empty: got valid=%b required 0", valid_o);
            errors++;
        end
    endtask

    task automatic test_flush();
        logic [3:0] w;
        w = 4'h5;
        ready_i = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        flush_i  = 1'b1;
        valid_i  = 1'b1;
        serial_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            $display("FAIL flush_busy: got busy=%b valid=%b required 0 0", busy_o, valid_o);
            errors++;
        end
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        checks++;
        if (parallel_o !== 4'h5 || valid_o !== 1'b1) begin
            $display("FAIL flush_word: got par=%h v=%b required par=5 v=1", parallel_o, valid_o);
            errors++;
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [3:0] w;
        logic [3:0] r;
        w = 4'h9;
        r = 4'h6;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if (busy_o !== 1'b1 || valid_o !== 1'b1 || parallel_o !== 4'h9) begin
            $display("FAIL arst_pre: got busy=%b v=%b par=%h required 1 1 9",
                     busy_o, valid_o, parallel_o);
            errors++;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || parallel_o !== 4'h0) begin
            $display("FAIL arst_async: got busy=%b v=%b par=%h required 0 0 0",
                     busy_o, valid_o, parallel_o);
            errors++;
        end
        @(negedge clk);
        reset   = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(r[i]);
        checks++;
        if (parallel_o !== 4'h6 || valid_o !== 1'b1) begin
            $display("FAIL arst_restart: got par=%h v=%b required par=6 v=1", parallel_o, valid_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_same_cycle_drain();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2p_rx.md
# s2p_rx

Serial-to-parallel receiver for the block's LSB-first bit-serial link. Collects `W` qualified serial bits into a word and presents it on a one-entry valid/ready output register. Sits at the far end of the link from the parallel-to-serial transmitter and hands assembled words to downstream parallel logic. Flags words dropped under backpressure with a sticky overrun flag.

## Interface
Parameters:
- `W`, default 4: word width in bits; legal range is 2 or more.

Ports:
- `clk`  input  1  clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `serial_i`  input  1  serial data bit, sampled only when `valid_i`=1.
- `valid_i`  input  1  qualifies `serial_i` for this cycle.
- `flush_i`  input  1  synchronous discard of the partial word.
- `ready_i`  input  1  downstream accepts `parallel_o` when `valid_o`=1.
- `clr_overrun_i`  input  1  synchronous clear of `overrun_o`.
- `parallel_o`  output  W  assembled word; bit 0 is the first bit received.
- `valid_o`  output  1  `parallel_o` holds an unconsumed word.
- `busy_o`  output  1  a partial word is in progress (bit count is not 0).
- `overrun_o`  output  1  sticky flag: a completed word was dropped.

## Operation
- State:
  - shift register `shreg[W-1:0]`.
  - bit counter `cnt`, width `$clog2(W)+1`, range 0..W-1.
  - output register with its valid bit.
  - overrun flag.
- Shifting: on a cycle with `valid_i`=1 and `flush_i`=0, `shreg <= {serial_i, shreg[W-1:1]}` and `cnt++`. The word lands LSB-first.
- Completion: a qualified bit arriving at `cnt==W-1` completes the word. The completed word is `{serial_i, shreg[W-1:1]}`, and `cnt` returns to 0.
- Load condition: `load_ok = !valid_o || ready_i`.
  - If `load_ok`: the completed word is written to `parallel_o` and `valid_o` is 1 next cycle.
  - Otherwise the word is dropped, `overrun_o` is set, and `parallel_o` and `valid_o` are unchanged.
- Handshake: a transfer happens when `valid_o && ready_i`. `valid_o` clears after a transfer unless a new word loads in the same cycle.
- Stability: `parallel_o` must not change while `valid_o`=1 and `ready_i`=0.
- Flush: `flush_i`=1 sets `cnt` to 0.
  - Any `valid_i` bit in the same cycle is discarded (flush wins).
  - The output register and `overrun_o` are unaffected.
- Overrun clear: `clr_overrun_i` clears `overrun_o`. A new overrun in the same cycle wins, so the flag stays 1.
- `busy_o = (cnt != 0)`.
- There is no state machine beyond the counter. Idle is `cnt==0`; collecting is `cnt` in 1..W-1.

## Timing
- Reset (asynchronous, when `reset`=0):
  - `parallel_o`=0, `valid_o`=0, `busy_o`=0, `overrun_o`=0.
  - `shreg`=0, `cnt`=0.
  - Outputs change immediately, without waiting for a clock edge.
- Reset mid-word or mid-handshake: the partial word and the held word are both lost. Operation restarts at bit 0 after the first edge following deassertion.
- Latency: if the last bit is sampled at edge k, `valid_o`=1 and `parallel_o` is valid after edge k.
- Throughput: one word every W qualified cycles with no bubbles when `ready_i`=1. Back-to-back words need no idle cycle.
- Gaps: `valid_i` may drop for any number of cycles mid-word. The count and shift contents hold during gaps.
- Backpressure edge case: if the word completes in the same cycle that `valid_o && ready_i` is true, the new word loads, `valid_o` stays 1, and no overrun occurs.
- Combinational paths: none from inputs to outputs. All outputs are registered (`busy_o` is decoded from the registered `cnt`).

## Structure
- Shared package `serdes_pkg`:
  - `SERDES_W_DEFAULT` = 4.
  - `cnt_w(W)` function returning `$clog2(W)+1`.
  - The package is shared with the transmitter so both ends agree on width and bit order.
- One sub-module, `s2p_hold_reg`:
  - a one-entry valid/ready register with `load`, `din`, `ready_i`, `dout`, `valid_o`;
  - it exports `load_ok`.
- The top level holds the shifter, counter, and overrun logic.

## Test plan
- Reset:
  - Hold `reset`=0 with random inputs: all outputs are 0.
  - Assert `reset`=0 asynchronously mid-word (after 2 bits): `busy_o` and `valid_o` drop before the next edge.
- Basic word (W=4, `ready_i`=1): bits 1,0,1,1 on 4 consecutive `valid_i` cycles. `parallel_o`=4'hD and `valid_o`=1 for exactly one cycle after the 4th edge. `busy_o`=1 after bits 1–3.
- Gapped input: bits 0,1,0,1 with 3 idle cycles between each. `parallel_o`=4'hA after the last bit, and `busy_o` stays high through the gaps.
- Overrun:
  - Send 4'hA then 4'h3 back-to-back with `ready_i`=0. `parallel_o` stays 4'hA, `overrun_o`=1, `valid_o`=1.
  - Raise `ready_i`: `valid_o` drops next cycle.
  - Pulse `clr_overrun_i`: `overrun_o`=0.
- Same-cycle drain: with `valid_o`=1 holding 4'h5, complete 4'hC in the cycle where `ready_i`=1. `parallel_o`=4'hC, `valid_o` stays 1, `overrun_o`=0.
- Flush:
  - Send 2 bits, then `flush_i`=1 together with `valid_i`=1. `busy_o`=0 and the bit is discarded.
  - Then send 1,0,1,0: `parallel_o`=4'h5.
